// File: rtl/adc_pkg.sv
// Shared definitions for the chip-array sequencer.
// Contents:
//   OP_*     operation codes.
//   state_e  sequencer state encoding, also exported as a debug output.
//   pick_op  start-request priority: init > type > conf > conv.
package adc_pkg;

    localparam logic [1:0] OP_INIT = 2'd0;
    localparam logic [1:0] OP_TYPE = 2'd1;
    localparam logic [1:0] OP_CONF = 2'd2;
    localparam logic [1:0] OP_CONV = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // fs is packed as {conv, conf, type, init}.
    function automatic logic [1:0] pick_op(input logic [3:0] fs);
        logic [1:0] op;
        op = OP_CONV;
        if (fs[2]) op = OP_CONF;
        if (fs[1]) op = OP_TYPE;
        if (fs[0]) op = OP_INIT;
        return op;
    endfunction

endpackage

// File: rtl/adc_done_tracker.sv
// Per-chip completion tracking for one fanned-out operation.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   start          latch enables (chip_en minus faulted chips), clear done flags and timer
//   run            one active RUN cycle: collect done flags and advance the timer
//   chip_en        raw per-chip enables
//   fdc            done levels of the operation in progress
//   timeout_cyc    RUN cycles allowed; 0 disables the timeout
//   en             latched enable mask
//   all_done       every enabled chip is done, including dones arriving this cycle
//   timeout        timer expired this RUN cycle without all_done
//   fault          sticky per-chip timeout flags, cleared only by rst
module adc_done_tracker #(
    parameter int NCHIP = 4,
    parameter int TMO_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             run,
    input  logic [NCHIP-1:0] chip_en,
    input  logic [NCHIP-1:0] fdc,
    input  logic [TMO_W-1:0] timeout_cyc,
    output logic [NCHIP-1:0] en,
    output logic             all_done,
    output logic             timeout,
    output logic [NCHIP-1:0] fault
);

    logic [NCHIP-1:0] en_q, en_d;
    logic [NCHIP-1:0] done_q, done_d;
    logic [NCHIP-1:0] fault_q, fault_d;
    logic [TMO_W-1:0] timer_q, timer_d;
    logic [NCHIP-1:0] done_nxt;

    always_comb begin
        en_d    = en_q;
        done_d  = done_q;
        fault_d = fault_q;
        timer_d = timer_q;
        // Dones arriving this cycle count immediately so completion
        // is reported one cycle after the last chip finishes.
        done_nxt = done_q | (fdc & en_q);
        all_done = &(done_nxt | ~en_q);
        timeout  = run && (timeout_cyc != '0) &&
                   (timer_q == timeout_cyc - TMO_W'(1)) && !all_done;
        if (start) begin
            en_d    = chip_en & ~fault_q;
            done_d  = '0;
            timer_d = '0;
        end else if (run) begin
            done_d  = done_nxt;
            timer_d = timer_q + TMO_W'(1);
            if (timeout) fault_d = fault_q | (en_q & ~done_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= '0;
            done_q  <= '0;
            fault_q <= '0;
            timer_q <= '0;
        end else begin
            en_q    <= en_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            timer_q <= timer_d;
        end
    end

    assign en    = en_q;
    assign fault = fault_q;

endmodule

// File: rtl/adc_array_ctrl.sv
// Start/done sequencer for an array of NCHIP chip engines.
// Handshake: all start/done signals are levels. A requester holds fs_<op>
// high until it sees fd_<op>; the sequencer holds fd_<op> until fs_<op>
// drops. The same contract applies per chip on fsc_<op>/fdc_<op>.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   fs_*/fd_*             upstream start requests / aggregated done levels
//   chip_en, timeout_cyc  per-chip enables and RUN timeout (0 = none)
//   fsc_*/fdc_*           per-chip start levels / per-chip done levels
//   temp_in               packed chip temperatures, chip i at [i*TEMP_W +: TEMP_W]
//   chip_temp, temp_cnt   temperature sum and contributor count of the last conv
//   fault, err            sticky timeout flags, timeout indication with fd_*
//   dbg_state             current sequencer state
module adc_array_ctrl
    import adc_pkg::*;
#(
    parameter int NCHIP  = 4,
    parameter int TEMP_W = 16,
    parameter int TMO_W  = 20
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  fs_init,
    input  logic                                  fs_type,
    input  logic                                  fs_conf,
    input  logic                                  fs_conv,
    output logic                                  fd_init,
    output logic                                  fd_type,
    output logic                                  fd_conf,
    output logic                                  fd_conv,
    input  logic [NCHIP-1:0]                      chip_en,
    input  logic [TMO_W-1:0]                      timeout_cyc,
    output logic [NCHIP-1:0]                      fsc_init,
    output logic [NCHIP-1:0]                      fsc_type,
    output logic [NCHIP-1:0]                      fsc_conf,
    output logic [NCHIP-1:0]                      fsc_conv,
    input  logic [NCHIP-1:0]                      fdc_init,
    input  logic [NCHIP-1:0]                      fdc_type,
    input  logic [NCHIP-1:0]                      fdc_conf,
    input  logic [NCHIP-1:0]                      fdc_conv,
    input  logic [NCHIP*TEMP_W-1:0]               temp_in,
    output logic [TEMP_W-2+$clog2(NCHIP+1)-1:0]   chip_temp,
    output logic [$clog2(NCHIP+1)-1:0]            temp_cnt,
    output logic [NCHIP-1:0]                      fault,
    output logic                                  err,
    output state_e                                dbg_state
);

    localparam int CNT_W = $clog2(NCHIP+1);
    localparam int SUM_W = TEMP_W - 2 + CNT_W;
    localparam int IDX_W = (NCHIP > 1) ? $clog2(NCHIP) : 1;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [NCHIP-1:0] fsc_q, fsc_d;
    logic             fd_q, fd_d;
    logic             err_q, err_d;
    logic             tmo_q, tmo_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] chip_temp_q, chip_temp_d;
    logic [CNT_W-1:0] temp_cnt_q, temp_cnt_d;

    logic [3:0]        fs_vec;
    logic              fs_sel;
    logic [NCHIP-1:0]  fdc_sel;
    logic [NCHIP-1:0]  en;
    logic              all_done;
    logic              timeout;
    logic [TEMP_W-1:0] t_sel;

    assign fs_vec = {fs_conv, fs_conf, fs_type, fs_init};
    assign fs_sel = fs_vec[op_q];
    assign t_sel  = temp_in[TEMP_W*int'(idx_q) +: TEMP_W];

    always_comb begin
        case (op_q)
            OP_INIT: fdc_sel = fdc_init;
            OP_TYPE: fdc_sel = fdc_type;
            OP_CONF: fdc_sel = fdc_conf;
            default: fdc_sel = fdc_conv;
        endcase
    end

    adc_done_tracker #(.NCHIP(NCHIP), .TMO_W(TMO_W)) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .start       (state_q == ST_IDLE && |fs_vec),
        .run         (state_q == ST_RUN && fs_sel),
        .chip_en     (chip_en),
        .fdc         (fdc_sel),
        .timeout_cyc (timeout_cyc),
        .en          (en),
        .all_done    (all_done),
        .timeout     (timeout),
        .fault       (fault)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        fsc_d       = fsc_q;
        fd_d        = fd_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        chip_temp_d = chip_temp_q;
        temp_cnt_d  = temp_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|fs_vec) begin
                    op_d    = pick_op(fs_vec);
                    // Same mask the tracker latches as its enable set.
                    fsc_d   = chip_en & ~fault;
                    tmo_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!fs_sel) begin
                    fsc_d   = '0;
                    state_d = ST_IDLE;
                end else if (all_done || timeout) begin
                    fsc_d = '0;
                    tmo_d = timeout;
                    if (op_q == OP_CONV) begin
                        idx_d   = '0;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_ACC;
                    end else begin
                        fd_d    = 1'b1;
                        err_d   = timeout;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ACC: begin
                if (!fs_sel) begin
                    state_d = ST_IDLE;
                end else begin
                    // Fault already includes chips that timed out in RUN.
                    if (en[idx_q] && !fault[idx_q]) begin
                        acc_d = acc_q + SUM_W'(t_sel[TEMP_W-1:2]);
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (idx_q == IDX_W'(NCHIP-1)) begin
                        chip_temp_d = acc_d;
                        temp_cnt_d  = cnt_d;
                        fd_d        = 1'b1;
                        err_d       = tmo_q;
                        state_d     = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                if (!fs_sel) begin
                    fd_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_INIT;
            fsc_q       <= '0;
            fd_q        <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
            idx_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            chip_temp_q <= '0;
            temp_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            fsc_q       <= fsc_d;
            fd_q        <= fd_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            chip_temp_q <= chip_temp_d;
            temp_cnt_q  <= temp_cnt_d;
        end
    end

    // op_q only changes in IDLE while fsc_q and fd_q are zero, so these
    // decodes never glitch onto a different operation.
    assign fsc_init  = (op_q == OP_INIT) ? fsc_q : '0;
    assign fsc_type  = (op_q == OP_TYPE) ? fsc_q : '0;
    assign fsc_conf  = (op_q == OP_CONF) ? fsc_q : '0;
    assign fsc_conv  = (op_q == OP_CONV) ? fsc_q : '0;
    assign fd_init   = fd_q && (op_q == OP_INIT);
    assign fd_type   = fd_q && (op_q == OP_TYPE);
    assign fd_conf   = fd_q && (op_q == OP_CONF);
    assign fd_conv   = fd_q && (op_q == OP_CONV);
    assign err       = err_q;
    assign chip_temp = chip_temp_q;
    assign temp_cnt  = temp_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_adc_array_ctrl.sv
// Bench for adc_array_ctrl (NCHIP=4, TEMP_W=16, TMO_W=20).
// Each directed operation pushes its expected completion record
// {latency, fd vector, err, fault, chip_temp, temp_cnt} into exp_q;
// the monitor pops one record per fd rising edge.
module tb_adc_array_ctrl;
    import adc_pkg::*;

    localparam int NCHIP  = 4;
    localparam int TEMP_W = 16;
    localparam int TMO_W  = 20;
    localparam int SUM_W  = 17;
    localparam int CNT_W  = 3;
    localparam int REC_W  = 8 + 4 + 1 + NCHIP + SUM_W + CNT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fs_init = 0, fs_type = 0, fs_conf = 0, fs_conv = 0;
    logic fd_init, fd_type, fd_conf, fd_conv;
    logic [NCHIP-1:0] chip_en = '0;
    logic [TMO_W-1:0] timeout_cyc = '0;
    logic [NCHIP-1:0] fsc_init, fsc_type, fsc_conf, fsc_conv;
    logic [NCHIP-1:0] fdc_init = '0, fdc_type = '0, fdc_conf = '0, fdc_conv = '0;
    logic [NCHIP*TEMP_W-1:0] temp_in = {4{16'h0400}};
    logic [SUM_W-1:0] chip_temp;
    logic [CNT_W-1:0] temp_cnt;
    logic [NCHIP-1:0] fault;
    logic err;
    state_e dbg_state;

    adc_array_ctrl #(.NCHIP(NCHIP), .TEMP_W(TEMP_W), .TMO_W(TMO_W)) dut (
        .clk(clk), .rst(rst),
        .fs_init(fs_init), .fs_type(fs_type), .fs_conf(fs_conf), .fs_conv(fs_conv),
        .fd_init(fd_init), .fd_type(fd_type), .fd_conf(fd_conf), .fd_conv(fd_conv),
        .chip_en(chip_en), .timeout_cyc(timeout_cyc),
        .fsc_init(fsc_init), .fsc_type(fsc_type), .fsc_conf(fsc_conf), .fsc_conv(fsc_conv),
        .fdc_init(fdc_init), .fdc_type(fdc_type), .fdc_conf(fdc_conf), .fdc_conv(fdc_conv),
        .temp_in(temp_in), .chip_temp(chip_temp), .temp_cnt(temp_cnt),
        .fault(fault), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [REC_W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int start_ref = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [REC_W-1:0] mk(input int lat, input logic [3:0] fdv, input logic e,
                                            input logic [NCHIP-1:0] f, input int t, input int c);
        return {8'(lat), fdv, e, f, SUM_W'(t), CNT_W'(c)};
    endfunction

    logic [3:0] fd_vec;
    logic       fd_prev = 1'b0;
    assign fd_vec = {fd_conv, fd_conf, fd_type, fd_init};

    always @(negedge clk) begin
        if (rst) begin
            fd_prev <= 1'b0;
        end else begin
            if (|fd_vec && !fd_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_fd", 64'(fd_vec), 64'(0));
                end else begin
                    chk("completion", 64'({8'(cyc - start_ref), fd_vec, err, fault, chip_temp, temp_cnt}),
                        64'(exp_q.pop_front()));
                end
            end
            fd_prev <= |fd_vec;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [3:0] fsv);
        @(negedge clk);
        {fs_conv, fs_conf, fs_type, fs_init} = fsv;
        start_ref = cyc;
    endtask

    task automatic wait_lat(input int k);
        while (cyc - start_ref < k) @(negedge clk);
    endtask

    task automatic wait_fd(input int budget);
        int n;
        n = 0;
        while (!(|fd_vec) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(|fd_vec)) chk("fd_wait_timeout", 64'(0), 64'(1));
    endtask

    task automatic drop_all();
        {fs_conv, fs_conf, fs_type, fs_init} = 4'b0;
        fdc_init = '0; fdc_type = '0; fdc_conf = '0; fdc_conv = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            64'({fd_vec, fsc_init, fsc_type, fsc_conf, fsc_conv, fault, err, chip_temp, temp_cnt, dbg_state}),
            64'(0));
        rst = 1'b0;

        // init, all chips, staggered dones
        chip_en = 4'hF;
        exp_q.push_back(mk(10, 4'b0001, 1'b0, 4'b0000, 0, 0));
        start_op(4'b0001);
        for (int k = 1; k <= 9; k++) begin
            wait_lat(k);
            if (k == 1) begin
                chk("t1_fsc_init", 64'(fsc_init), 64'(4'hF));
                chk("t1_fsc_other", 64'({fsc_type, fsc_conf, fsc_conv}), 64'(0));
            end
            if (k == 3) fdc_init[0] = 1'b1;
            if (k == 5) fdc_init[1] = 1'b1;
            if (k == 7) fdc_init[2] = 1'b1;
            if (k == 9) fdc_init[3] = 1'b1;
        end
        wait_fd(20);
        drop_all();
        @(negedge clk);
        chk("t1_fd_release", 64'({fd_init, err, dbg_state}), 64'({1'b0, 1'b0, ST_IDLE}));

        // conv on chips 0 and 2, 256 each
        chip_en = 4'b0101;
        exp_q.push_back(mk(7, 4'b1000, 1'b0, 4'b0000, 512, 2));
        start_op(4'b1000);
        wait_lat(1);
        chk("t2_fsc_conv", 64'(fsc_conv), 64'(4'b0101));
        wait_lat(2);
        fdc_conv = 4'b0111;  // chip 1 is disabled; its done must be ignored
        wait_fd(20);
        drop_all();
        @(negedge clk);

        // conf with chip 2 hung, timeout 10
        timeout_cyc = 20'd10;
        chip_en = 4'hF;
        exp_q.push_back(mk(11, 4'b0100, 1'b1, 4'b0100, 512, 2));
        start_op(4'b0100);
        wait_lat(2);
        fdc_conf = 4'b1011;
        wait_fd(30);
        drop_all();
        @(negedge clk);
        chk("t3_err_release", 64'({fd_conf, err}), 64'(0));

        // following op skips the faulted chip
        exp_q.push_back(mk(3, 4'b0001, 1'b0, 4'b0100, 512, 2));
        start_op(4'b0001);
        wait_lat(1);
        chk("t3_fsc_excl", 64'(fsc_init), 64'(4'b1011));
        wait_lat(2);
        fdc_init = 4'b1011;
        wait_fd(20);
        drop_all();
        @(negedge clk);

        // type and conv together, no chips enabled
        chip_en = 4'b0000;
        exp_q.push_back(mk(2, 4'b0010, 1'b0, 4'b0100, 512, 2));
        start_op(4'b1010);
        wait_fd(20);
        drop_all();
        @(negedge clk);

        // conv aborted mid-RUN
        timeout_cyc = '0;
        chip_en = 4'hF;
        start_op(4'b1000);
        wait_lat(3);
        chk("t5_fsc_conv", 64'(fsc_conv), 64'(4'b1011));
        drop_all();
        wait_lat(4);
        chk("t5_fsc_abort", 64'(fsc_conv), 64'(0));
        repeat (5) @(negedge clk);
        chk("t5_temp_held", 64'({chip_temp, temp_cnt, dbg_state}), 64'({17'd512, 3'd2, ST_IDLE}));

        // reset during ACC
        start_op(4'b1000);
        wait_lat(2);
        fdc_conv = 4'b1011;
        wait_lat(4);
        rst = 1'b1;
        drop_all();
        @(negedge clk);
        chk("t6_reset_acc",
            64'({fd_vec, fsc_init, fsc_type, fsc_conf, fsc_conv, fault, err, chip_temp, temp_cnt, dbg_state}),
            64'(0));
        rst = 1'b0;
        repeat (5) @(negedge clk);

        chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
